// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receiver (8N1, LSB first) with a valid/ready byte port.
// Define UART_RX_PARITY_EN to receive 8E1 frames and drive parity_err.
module uart_rx_core #(
    parameter int unsigned CLK_FREQ   = 100000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun_err,
    output logic       parity_err
);

    localparam int unsigned DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned PH_W    = $clog2(OVERSAMPLE);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [PH_W-1:0]  PH_START = PH_W'(OVERSAMPLE / 2 - 1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_e;

    state_e           state_q, state_d;
    logic             rx_meta_q, rx_s_q, rx_prev_q;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_err_q, overrun_err_d;
`ifdef UART_RX_PARITY_EN
    logic             par_err_q, par_err_d;
    logic             parity_err_q, parity_err_d;
`endif

    logic tick, mid, fell, deliver;

    assign tick = (div_cnt_q == DIV_LAST);
    assign mid  = tick && (phase_q == PH_LAST);
    assign fell = rx_prev_q && !rx_s_q;

    always_comb begin
        // NOTE: every next-state value gets a default first, so no branch can infer a latch.
        state_d       = state_q;
        div_cnt_d     = tick ? '0 : div_cnt_q + DIV_W'(1);
        phase_d       = phase_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q && !rx_ready;
        frame_err_d   = 1'b0;
        overrun_err_d = 1'b0;
        deliver       = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_d     = par_err_q;
        parity_err_d  = 1'b0;
`endif
        if (tick) begin
            phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                phase_d = '0;
                // Restart the prescaler so the start bit is timed from its own edge.
                if (fell) begin
                    state_d   = S_START;
                    div_cnt_d = '0;
                end
            end
            S_START: begin
                if (tick && phase_q == PH_START) begin
                    if (!rx_s_q) begin
                        state_d   = S_DATA;
                        phase_d   = '0;
                        bit_cnt_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (mid) begin
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (mid) begin
                    par_err_d = rx_s_q ^ (^shift_q);
                    state_d   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (mid) begin
                    state_d = S_IDLE;
                    if (!rx_s_q) begin
                        frame_err_d = 1'b1;
                    end
`ifdef UART_RX_PARITY_EN
                    else if (par_err_q) begin
                        parity_err_d = 1'b1;
                    end
`endif
                    else begin
                        deliver = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A full holding register keeps its byte unless it is being accepted this cycle.
        if (deliver) begin
            if (rx_valid_q && !rx_ready) begin
                overrun_err_d = 1'b1;
            end else begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end
        end
    end

    // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            rx_meta_q     <= 1'b1;
            rx_s_q        <= 1'b1;
            rx_prev_q     <= 1'b1;
            div_cnt_q     <= '0;
            phase_q       <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q     <= 1'b0;
            parity_err_q  <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            rx_meta_q     <= uart_rx;
            rx_s_q        <= rx_meta_q;
            rx_prev_q     <= rx_s_q;
            div_cnt_q     <= div_cnt_d;
            phase_q       <= phase_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            frame_err_q   <= frame_err_d;
            overrun_err_q <= overrun_err_d;
`ifdef UART_RX_PARITY_EN
            par_err_q     <= par_err_d;
            parity_err_q  <= parity_err_d;
`endif
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_err_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err  = parity_err_q;
`else
    assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed bench for uart_rx_core at 16 clk per bit.
// Event counters on the falling clock edge give per-step deltas for pulses and deliveries.
module tb_uart_rx_core;

    localparam int BIT_CLK = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       uart_rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun_err;
    logic       parity_err;

    uart_rx_core #(
        .CLK_FREQ   (1843200),
        .BAUD       (115200),
        .OVERSAMPLE (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .uart_rx     (uart_rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .parity_err  (parity_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int         n_valid   = 0;
    int         n_frame   = 0;
    int         n_overrun = 0;
    int         n_parity  = 0;
    logic [7:0] last_data = 8'h00;

    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            n_valid   <= n_valid + 1;
            last_data <= rx_data;
        end
        if (frame_err === 1'b1)   n_frame   <= n_frame + 1;
        if (overrun_err === 1'b1) n_overrun <= n_overrun + 1;
        if (parity_err === 1'b1)  n_parity  <= n_parity + 1;
    end

    int b_valid, b_frame, b_overrun, b_parity;

    task automatic snap();
        b_valid   = n_valid;
        b_frame   = n_frame;
        b_overrun = n_overrun;
        b_parity  = n_parity;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b);
        uart_rx = b;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    // Correct even parity is inserted automatically when the parity build is selected.
    task automatic send(input logic [7:0] d, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(^d);
`endif
        drive_bit(stop);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_par(input logic [7:0] d, input logic par);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(par);
        drive_bit(1'b1);
    endtask
`endif

    initial begin
        rst      = 1'b1;
        uart_rx  = 1'b1;
        rx_ready = 1'b1;
        idle(3);
        check("rst_data",    32'(rx_data),     32'h00);
        check("rst_valid",   32'(rx_valid),    32'h0);
        check("rst_frame",   32'(frame_err),   32'h0);
        check("rst_overrun", 32'(overrun_err), 32'h0);
        check("rst_parity",  32'(parity_err),  32'h0);
        rst = 1'b0;
        idle(20);

        // 1: plain byte, consumer always ready
        snap();
        send(8'hA5, 1'b1);
        idle(8);
        check("t1_valid_cycles", 32'(n_valid - b_valid),     32'd1);
        check("t1_data",         32'(last_data),             32'hA5);
        check("t1_frame",        32'(n_frame - b_frame),     32'd0);
        check("t1_overrun",      32'(n_overrun - b_overrun), 32'd0);
        check("t1_valid_now",    32'(rx_valid),              32'h0);

        // 2: short low glitch is a false start
        snap();
        uart_rx = 1'b0;
        idle(4);
        uart_rx = 1'b1;
        idle(40);
        check("t2_valid_cycles", 32'(n_valid - b_valid), 32'd0);
        check("t2_errors", 32'((n_frame - b_frame) + (n_overrun - b_overrun) + (n_parity - b_parity)), 32'd0);
        check("t2_valid_now",    32'(rx_valid), 32'h0);

        // 3: bad stop bit, then a good frame
        snap();
        send(8'h3C, 1'b0);
        uart_rx = 1'b1;
        idle(20);
        check("t3_frame",        32'(n_frame - b_frame),     32'd1);
        check("t3_valid_cycles", 32'(n_valid - b_valid),     32'd0);
        check("t3_overrun",      32'(n_overrun - b_overrun), 32'd0);
        snap();
        send(8'h81, 1'b1);
        idle(8);
        check("t3b_valid_cycles", 32'(n_valid - b_valid), 32'd1);
        check("t3b_data",         32'(last_data),         32'h81);
        check("t3b_frame",        32'(n_frame - b_frame), 32'd0);

        // 4: consumer stalled across two back-to-back frames
        rx_ready = 1'b0;
        snap();
        send(8'h11, 1'b1);
        send(8'h22, 1'b1);
        idle(8);
        check("t4_valid_held", 32'(rx_valid),              32'h1);
        check("t4_data_kept",  32'(rx_data),               32'h11);
        check("t4_overrun",    32'(n_overrun - b_overrun), 32'd1);
        check("t4_frame",      32'(n_frame - b_frame),     32'd0);
        rx_ready = 1'b1;
        idle(1);
        rx_ready = 1'b0;
        check("t4_valid_after_accept", 32'(rx_valid), 32'h0);
        check("t4_data_after_accept",  32'(rx_data),  32'h11);
        rx_ready = 1'b1;
        idle(4);

        // 5: reset after the third data bit of 0xF0 (start and bits 0..2 are all low)
        uart_rx = 1'b0;
        idle(4 * BIT_CLK);
        uart_rx = 1'b1;
        rst     = 1'b1;
        idle(1);
        check("t5_rst_data",    32'(rx_data),     32'h00);
        check("t5_rst_valid",   32'(rx_valid),    32'h0);
        check("t5_rst_frame",   32'(frame_err),   32'h0);
        check("t5_rst_overrun", 32'(overrun_err), 32'h0);
        check("t5_rst_parity",  32'(parity_err),  32'h0);
        rst = 1'b0;
        idle(20);
        snap();
        send(8'h5A, 1'b1);
        idle(8);
        check("t5_valid_cycles", 32'(n_valid - b_valid), 32'd1);
        check("t5_data",         32'(last_data),         32'h5A);
        check("t5_errors", 32'((n_frame - b_frame) + (n_overrun - b_overrun) + (n_parity - b_parity)), 32'd0);

`ifdef UART_RX_PARITY_EN
        // 6: 0x07 has three ones, so even parity requires a 1
        snap();
        send_par(8'h07, 1'b0);
        idle(8);
        check("t6_parity",       32'(n_parity - b_parity), 32'd1);
        check("t6_valid_cycles", 32'(n_valid - b_valid),   32'd0);
        check("t6_frame",        32'(n_frame - b_frame),   32'd0);
        snap();
        send_par(8'h07, 1'b1);
        idle(8);
        check("t6b_valid_cycles", 32'(n_valid - b_valid),   32'd1);
        check("t6b_data",         32'(last_data),           32'h07);
        check("t6b_parity",       32'(n_parity - b_parity), 32'd0);
`else
        check("parity_never_pulsed", 32'(n_parity), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
